// File: rtl/bmf_stream_decoder.sv
// ============================================================================
// Module      : bmf_stream_decoder
// Description : Programmable Boolean-matrix-factorization decoder; each output
//               word is the OR of the basis rows selected by a latent code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bmf_stream_decoder #(
    parameter int K  = 3,
    parameter int M  = 6,
    parameter int CW = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cfg_we,
    input  logic [((K > 1) ? $clog2(K) : 1)-1:0]   cfg_row,
    input  logic [M-1:0]                           cfg_data,
    output logic                                   cfg_ready,
    output logic                                   cfg_err,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [K-1:0]                           in_code,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [M-1:0]                           out_data,
    output logic [CW-1:0]                          dec_cnt,
    input  logic                                   clr_stats
);

    localparam int            C_RW = (K > 1) ? $clog2(K) : 1;
    localparam logic [C_RW:0] C_K  = (C_RW + 1)'(K);

    logic [K-1:0][M-1:0] r_h;
    logic                r_out_valid;
    logic [M-1:0]        r_out_data;
    logic [CW-1:0]       r_cnt;
    logic                r_err;

    logic                w_cfg_wr;
    logic                w_row_ok;
    logic                w_in_hs;
    logic                w_out_hs;
    logic [M-1:0]        w_dec;

    // Config only lands with an empty output stage, so no decode ever sees a mixed H
    assign cfg_ready = !r_out_valid;
    assign in_ready  = (!r_out_valid | out_ready) & !cfg_we;
    assign w_cfg_wr  = cfg_we & cfg_ready;
    assign w_row_ok  = ({1'b0, cfg_row} < C_K);
    assign w_in_hs   = in_valid & in_ready;
    assign w_out_hs  = r_out_valid & out_ready;

    always_comb begin
        w_dec = '0;
        for (int i = 0; i < K; i++) begin
            if (in_code[i]) begin
                w_dec = w_dec | r_h[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
        end else if (w_cfg_wr && w_row_ok) begin
            r_h[cfg_row] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_in_hs) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_dec;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr_stats) begin
            r_cnt <= '0;
        end else if (w_out_hs) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A same-cycle bad write wins over the clear so the error is never lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_cfg_wr && !w_row_ok) begin
            r_err <= 1'b1;
        end else if (clr_stats) begin
            r_err <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign dec_cnt   = r_cnt;
    assign cfg_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bmf_stream_decoder.sv
// ============================================================================
// Module      : tb_bmf_stream_decoder
// Description : Directed scoreboard bench for bmf_stream_decoder (K=3, M=6, CW=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bmf_stream_decoder;

    localparam int C_K  = 3;
    localparam int C_M  = 6;
    localparam int C_CW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_row = '0;
    logic [C_M-1:0] cfg_data = '0;
    logic           cfg_ready;
    logic           cfg_err;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [C_K-1:0] in_code = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [C_M-1:0] out_data;
    logic [C_CW-1:0] dec_cnt;
    logic           clr_stats = 1'b0;

    int             n_cmp = 0;
    int             n_bad = 0;
    logic [C_M-1:0] sb[$];
    logic [C_M-1:0] mh [C_K];
    int             waits;

    bmf_stream_decoder #(.K(C_K), .M(C_M), .CW(C_CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_row   (cfg_row),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .dec_cnt   (dec_cnt),
        .clr_stats (clr_stats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [C_M-1:0] model(input logic [C_K-1:0] c);
        logic [C_M-1:0] r;
        r = '0;
        for (int i = 0; i < C_K; i++) if (c[i]) r |= mh[i];
        return r;
    endfunction

    // Drive one code and wait for its handshake; expected word enters the scoreboard
    task automatic send(input logic [C_K-1:0] c);
        in_valid = 1'b1;
        in_code  = c;
        waits    = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(c));
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            waits++;
            @(posedge clk); #1;
        end
        chk("send_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] row, input logic [C_M-1:0] d);
        cfg_we   = 1'b1;
        cfg_row  = row;
        cfg_data = d;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (cfg_ready) begin
                if (row < C_K) mh[row] = d;
                @(posedge clk); #1;
                cfg_we = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("cfg_timeout", 32'd1, 32'd0);
        cfg_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
    endtask

    // Output monitor: every accepted word must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", {26'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                chk("out_data", {26'd0, out_data}, {26'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < C_K; i++) mh[i] = '0;
        idle(2);
        #2 rst = 1'b0;
        idle(1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {26'd0, out_data}, 32'd0);
        chk("rst_dec_cnt",   {28'd0, dec_cnt}, 32'd0);
        chk("rst_cfg_err",   {31'd0, cfg_err}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);

        // Zero basis: any code decodes to zero, latency one cycle
        send(3'b111);
        chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_out_data",  {26'd0, out_data}, 32'd0);
        idle(2);
        chk("cnt_after_one", {28'd0, dec_cnt}, 32'd1);

        cfg(2'd0, 6'b001000);
        cfg(2'd1, 6'b010001);
        cfg(2'd2, 6'b100000);
        clr();
        send(3'b011); chk("b2b_wait0", waits, 0);
        send(3'b100); chk("b2b_wait1", waits, 0);
        send(3'b111); chk("b2b_wait2", waits, 0);
        idle(2);
        chk("cnt_b2b", {28'd0, dec_cnt}, 32'd3);

        // Backpressure with a second code held pending
        send(3'b001);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 3'b010;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("bp_data",     {26'd0, out_data}, {26'd0, mh[0]});
            chk("bp_valid",    {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(3'b010);
        idle(2);
        chk("bp_cnt", {28'd0, dec_cnt}, 32'd5);
        chk("bp_sb_empty", sb.size(), 0);

        // Config request while a word is held
        send(3'b100);
        out_ready = 1'b0;
        cfg_we    = 1'b1;
        cfg_row   = 2'd2;
        cfg_data  = 6'b000110;
        @(negedge clk);
        chk("cfgst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        chk("cfgst_in_ready",  {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        cfg(2'd2, 6'b000110);
        send(3'b100);
        idle(2);
        chk("cfgst_new_row", {26'd0, out_data}, 32'h06);

        // Out-of-range row: H untouched, sticky error
        cfg(2'd3, 6'b111111);
        idle(3);
        chk("err_set", {31'd0, cfg_err}, 32'd1);
        send(3'b111);
        idle(2);
        chk("err_h_kept", {26'd0, out_data}, 32'h3F & {26'd0, model(3'b111)});
        clr();
        chk("clr_err", {31'd0, cfg_err}, 32'd0);
        chk("clr_cnt", {28'd0, dec_cnt}, 32'd0);
        cfg_we = 1'b1; cfg_row = 2'd3; cfg_data = '1; clr_stats = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; clr_stats = 1'b0;
        chk("clr_vs_bad_write", {31'd0, cfg_err}, 32'd1);
        clr();
        chk("clr_err2", {31'd0, cfg_err}, 32'd0);

        // Counter wrap at CW=4
        for (int i = 0; i < 17; i++) send(3'(i));
        idle(2);
        chk("cnt_wrap", {28'd0, dec_cnt}, 32'd1);
        chk("wrap_sb_empty", sb.size(), 0);

        // Asynchronous reset discards the held word and clears H
        send(3'b011);
        out_ready = 1'b0;
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_data",  {26'd0, out_data}, 32'd0);
        sb.delete();
        for (int i = 0; i < C_K; i++) mh[i] = '0;
        idle(1);
        rst = 1'b0;
        out_ready = 1'b1;
        idle(1);
        send(3'b111);
        idle(2);
        chk("arst_h_zero", {26'd0, out_data}, 32'd0);
        chk("final_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bmf_stream_decoder.md
Name: bmf_stream_decoder

Overview:
- Programmable Boolean-matrix-factorization decompressor: the decoder end of a BMF partition.
- Holds a K x M Boolean basis matrix H, loaded through a config port.
- Accepts a stream of K-bit latent codes over a valid/ready handshake and emits M-bit reconstructed outputs: out = OR over i of (code[i] AND H[i]).
- Sits downstream of a partition's compressor stage, so one silicon block can evaluate many approximate factorizations without resynthesis.

Parameters:
- K, 3, latent code width (number of basis rows); 1..8.
- M, 6, output width (columns of H); 1..32.
- CW, 16, width of decoded-word counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_we  input  1  write request for one basis row.
- cfg_row  input  max(1,clog2(K))  row index to write.
- cfg_data  input  M  row contents; bit j set means latent bit drives output j.
- cfg_ready  output  1  config write will be accepted this cycle.
- cfg_err  output  1  sticky: an accepted write had cfg_row >= K.
- in_valid  input  1  latent code valid.
- in_ready  output  1  decoder can accept a code.
- in_code  input  K  latent code; bit i selects row i.
- out_valid  output  1  decoded word valid.
- out_ready  input  1  downstream accepts word.
- out_data  output  M  decoded word.
- dec_cnt  output  CW  count of completed output handshakes.
- clr_stats  input  1  synchronous clear of dec_cnt and cfg_err.

Behaviour:
- Reset values: H all zero, out_valid=0, out_data=0, dec_cnt=0, cfg_err=0.
- Reset asserted mid-transfer discards the word held in the output register.
- Decode function: out_data[j] = OR over i<K of (in_code[i] & H[i][j]). An all-zero code gives all-zero output. With H all zero, every output is zero.
- Pipeline: one registered stage, latency 1 cycle from input handshake to out_valid.
- in_ready = (!out_valid | out_ready) & !cfg_we.
- On in_valid & in_ready: out_data and out_valid load next edge.
- Else if out_ready: out_valid clears.
- A handshake in the same cycle as an output handshake sustains full throughput of 1 word/cycle.
- out_data holds stable while out_valid & !out_ready.
- Config:
  - cfg_ready = !out_valid.
  - A write occurs on cfg_we & cfg_ready: H[cfg_row] <= cfg_data at the edge.
  - cfg_we while cfg_ready=0 is not a write; the requester holds cfg_we until cfg_ready.
  - cfg_we has priority over the stream (in_ready forced 0), so no code is decoded with a partially updated H.
  - A write whose cfg_row >= K leaves H unchanged and sets cfg_err; cfg_err stays set until clr_stats or rst.
  - The new row is used by the first code accepted after the write edge.
- Counter: dec_cnt increments on out_valid & out_ready and wraps modulo 2^CW.
  - clr_stats clears dec_cnt to 0 at the edge and overrides a same-cycle increment.
  - clr_stats clears cfg_err at the edge unless the same cycle carries an out-of-range accepted write; then cfg_err ends set.
- No combinational path from in_* to out_*. in_ready depends combinationally on out_ready and cfg_we only.

Test Plan:
- Reset, then decode code 3'b111 with H zero -> out_data=6'b000000 one cycle after handshake; dec_cnt=1.
- Load H[0]=6'b001000, H[1]=6'b010001, H[2]=6'b100000; stream codes 3'b011, 3'b100, 3'b111 back-to-back with out_ready=1:
  - outputs 6'b011001, 6'b100000, 6'b111001 on consecutive cycles;
  - in_ready stays 1 throughout;
  - dec_cnt=3.
- Backpressure: out_ready=0 for 4 cycles after first word with in_valid held:
  - out_data stable;
  - in_ready=0;
  - no word lost or duplicated after release.
- Config during stream:
  - assert cfg_we while out_valid=1 -> cfg_ready=0 and in_ready=0;
  - after drain, write lands, and the next code uses the new row.
- Write cfg_row=3 (K=3) -> H unchanged, cfg_err=1; clr_stats -> cfg_err=0, dec_cnt=0.
- CW=4: complete 17 handshakes -> dec_cnt=1. Assert rst while out_valid=1 -> out_valid=0 immediately (asynchronous), H zero.
